// File: rtl/sao_stat_n_acc_if.sv
// Beat-in / result-out bundle of the SAO statistics accumulator.
// The master drives beats and accepts results; the slave is the accumulator.
interface sao_stat_n_acc_if #(
  parameter int unsigned NPIX          = 7,
  parameter int unsigned DIFF_CLIP_BIT = 4,
  parameter int unsigned N_BO_TYPE     = 5,
  parameter int unsigned ACC_W         = 16,
  parameter int unsigned CNT_W         = 12
);
  logic                                in_valid;
  logic                                in_ready;
  logic                                in_first;
  logic                                in_last;
  logic [NPIX-1:0]                     lane_mask;
  logic [NPIX-1:0][N_BO_TYPE-1:0]      cate;
  logic [NPIX-1:0][DIFF_CLIP_BIT:0]    diff;
  logic                                out_valid;
  logic                                out_ready;
  logic signed [ACC_W-1:0]             out_sum;
  logic [CNT_W-1:0]                    out_cnt;
  logic                                out_sat;

  modport master (
    output in_valid, in_first, in_last, lane_mask, cate, diff, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, lane_mask, cate, diff, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_sat
  );
endinterface

// File: rtl/sao_stat_n_acc.sv
// SAO statistics accumulator: per block, saturated sum and count of the diffs
// of masked lanes whose category matches cate_target; one result per block.
module sao_stat_n_acc #(
  parameter int unsigned NPIX          = 7,
  parameter int unsigned DIFF_CLIP_BIT = 4,
  parameter int unsigned N_BO_TYPE     = 5,
  parameter int unsigned ACC_W         = 16,
  parameter int unsigned CNT_W         = 12
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 en,
  input  logic [N_BO_TYPE-1:0] cate_target,
  sao_stat_n_acc_if.slave      bus
);

  localparam int unsigned PSUM_W = DIFF_CLIP_BIT + 1 + $clog2(NPIX);
  localparam int unsigned PCNT_W = $clog2(NPIX + 1);
  localparam logic signed [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_FLUSH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept_c;

  logic                     in_ready_q, out_valid_q;
  logic signed [PSUM_W-1:0] psum_c, psum_q;
  logic [PCNT_W-1:0]        pcnt_c, pcnt_q;
  logic                     pvalid_q, pfirst_q, plast_q;
  logic signed [ACC_W-1:0]  acc_q, nsum_c, out_sum_q;
  logic [CNT_W-1:0]         cnt_q, ncnt_c, out_cnt_q;
  logic                     sat_q, nsat_c, out_sat_q;
  logic signed [ACC_W:0]    sum_wide_c;
  logic [CNT_W:0]           cnt_wide_c;
  logic signed [ACC_W-1:0]  base_sum_c;
  logic [CNT_W-1:0]         base_cnt_c;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_ACC;
    else if (en) state <= state_nxt;
  end

  // Next state; FLUSH lasts exactly one enabled edge, the one that retires plast
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    if (en) begin
      case (state)
        S_ACC: begin
          accept_c = bus.in_valid;
          if (bus.in_valid && bus.in_last) state_nxt = S_FLUSH;
        end
        S_FLUSH: state_nxt = S_HOLD;
        S_HOLD:  if (bus.out_ready) state_nxt = S_ACC;
        default: state_nxt = S_ACC;
      endcase
    end
  end

  // Stage 1: per-beat partial sum and popcount of matching lanes
  always_comb begin
    psum_c = '0;
    pcnt_c = '0;
    for (int unsigned i = 0; i < NPIX; i++) begin
      if (bus.lane_mask[i] && (bus.cate[i] == cate_target)) begin
        psum_c = psum_c + PSUM_W'($signed(bus.diff[i]));
        pcnt_c = pcnt_c + PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pvalid_q <= 1'b0;
      pfirst_q <= 1'b0;
      plast_q  <= 1'b0;
      psum_q   <= '0;
      pcnt_q   <= '0;
    end else if (en) begin
      pvalid_q <= accept_c;
      if (accept_c) begin
        pfirst_q <= bus.in_first;
        plast_q  <= bus.in_last;
        psum_q   <= psum_c;
        pcnt_q   <= pcnt_c;
      end
    end
  end

  // Stage 2: saturating accumulate; a first beat restarts from zero
  always_comb begin
    base_sum_c = pfirst_q ? '0 : acc_q;
    base_cnt_c = pfirst_q ? '0 : cnt_q;
    sum_wide_c = (ACC_W+1)'(base_sum_c) + (ACC_W+1)'(psum_q);
    cnt_wide_c = (CNT_W+1)'(base_cnt_c) + (CNT_W+1)'(pcnt_q);
    nsum_c     = sum_wide_c[ACC_W-1:0];
    ncnt_c     = cnt_wide_c[CNT_W-1:0];
    nsat_c     = pfirst_q ? 1'b0 : sat_q;
    if (sum_wide_c[ACC_W] != sum_wide_c[ACC_W-1]) begin
      nsum_c = sum_wide_c[ACC_W] ? SUM_MIN : SUM_MAX;
      nsat_c = 1'b1;
    end
    if (cnt_wide_c[CNT_W]) begin
      ncnt_c = '1;
      nsat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
    end else if (en && pvalid_q) begin
      if (plast_q) begin
        out_sum_q <= nsum_c;
        out_cnt_q <= ncnt_c;
        out_sat_q <= nsat_c;
        acc_q     <= '0;
        cnt_q     <= '0;
        sat_q     <= 1'b0;
      end else begin
        acc_q <= nsum_c;
        cnt_q <= ncnt_c;
        sat_q <= nsat_c;
      end
    end
  end

  // Handshake flags registered from the next state
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (en) begin
      in_ready_q  <= (state_nxt == S_ACC);
      out_valid_q <= (state_nxt == S_HOLD);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sao_stat_n_acc.sv
// Bench for sao_stat_n_acc: a 16/12-bit and an 8/6-bit instance run in lockstep
// on the same beats and are checked against an integer block model.
module tb_sao_stat_n_acc;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       en = 1'b1;
  logic [4:0] cate_target = 5'd0;

  always #5 clk = ~clk;

  sao_stat_n_acc_if #(.NPIX(7), .DIFF_CLIP_BIT(4), .N_BO_TYPE(5), .ACC_W(16), .CNT_W(12)) bus16 ();
  sao_stat_n_acc_if #(.NPIX(7), .DIFF_CLIP_BIT(4), .N_BO_TYPE(5), .ACC_W(8),  .CNT_W(6))  bus8 ();

  assign bus8.in_valid  = bus16.in_valid;
  assign bus8.in_first  = bus16.in_first;
  assign bus8.in_last   = bus16.in_last;
  assign bus8.lane_mask = bus16.lane_mask;
  assign bus8.cate      = bus16.cate;
  assign bus8.diff      = bus16.diff;
  assign bus8.out_ready = bus16.out_ready;

  sao_stat_n_acc #(.NPIX(7), .DIFF_CLIP_BIT(4), .N_BO_TYPE(5), .ACC_W(16), .CNT_W(12)) u_dut16 (
    .clk(clk), .arst_n(arst_n), .en(en), .cate_target(cate_target), .bus(bus16.slave));
  sao_stat_n_acc #(.NPIX(7), .DIFF_CLIP_BIT(4), .N_BO_TYPE(5), .ACC_W(8), .CNT_W(6)) u_dut8 (
    .clk(clk), .arst_n(arst_n), .en(en), .cate_target(cate_target), .bus(bus8.slave));

  int     vectors = 0;
  int     errors  = 0;
  bit     en_rand = 1'b0;
  longint m_sum[2];
  longint m_cnt[2];
  bit     m_sat[2];
  longint e_sum[2];
  longint e_cnt[2];
  bit     e_sat[2];

  function automatic int acc_w(input int j);
    return (j == 0) ? 16 : 8;
  endfunction

  function automatic int cnt_w(input int j);
    return (j == 0) ? 12 : 6;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < 2; j++) begin
      m_sum[j] = 0;
      m_cnt[j] = 0;
      m_sat[j] = 1'b0;
    end
  endfunction

  // Block-level reference: each beat adds its matching diffs/count, clamped to the widths
  function automatic void model_beat(input logic [6:0] m, input int c[7], input int d[7],
                                     input bit f, input bit l);
    longint ps = 0;
    longint pc = 0;
    for (int i = 0; i < 7; i++) begin
      if (m[i] && (c[i] == int'(cate_target))) begin
        ps += d[i];
        pc += 1;
      end
    end
    for (int j = 0; j < 2; j++) begin
      longint s    = (f ? 0 : m_sum[j]) + ps;
      longint n    = (f ? 0 : m_cnt[j]) + pc;
      bit     sat  = f ? 1'b0 : m_sat[j];
      longint hi   = (longint'(1) <<< (acc_w(j) - 1)) - 1;
      longint lo   = -(longint'(1) <<< (acc_w(j) - 1));
      longint cmax = (longint'(1) <<< cnt_w(j)) - 1;
      if (s > hi) begin s = hi; sat = 1'b1; end
      if (s < lo) begin s = lo; sat = 1'b1; end
      if (n > cmax) begin n = cmax; sat = 1'b1; end
      if (l) begin
        e_sum[j] = s; e_cnt[j] = n; e_sat[j] = sat;
        m_sum[j] = 0; m_cnt[j] = 0; m_sat[j] = 1'b0;
      end else begin
        m_sum[j] = s; m_cnt[j] = n; m_sat[j] = sat;
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic present(input logic [6:0] m, input int c[7], input int d[7], input bit f, input bit l);
    bus16.in_valid  = 1'b1;
    bus16.in_first  = f;
    bus16.in_last   = l;
    bus16.lane_mask = m;
    for (int i = 0; i < 7; i++) begin
      bus16.cate[i] = 5'(c[i]);
      bus16.diff[i] = 5'(d[i]);
    end
  endtask

  task automatic send_beat(input logic [6:0] m, input int c[7], input int d[7], input bit f, input bit l);
    int guard = 0;
    present(m, c, d, f, l);
    while (!(bus16.in_ready && en)) begin
      tick();
      guard++;
      if (guard > 300) begin
        vectors++; errors++;
        $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus16.in_ready, guard);
        bus16.in_valid = 1'b0;
        return;
      end
    end
    tick();
    bus16.in_valid = 1'b0;
    model_beat(m, c, d, f, l);
    if (en_rand && ($urandom_range(0, 2) == 0)) tick();
  endtask

  task automatic check_result(input string name, input int hold);
    int guard = 0;
    while (!bus16.out_valid) begin
      tick();
      guard++;
      if (guard > 300) begin
        vectors++; errors++;
        $display("FAIL %s out_valid_timeout: out_valid=0, required 1", name);
        return;
      end
    end
    vectors++;
    if (bus16.out_sum !== 16'(e_sum[0])) begin
      errors++; $display("FAIL %s sum16: got %0d required %0d", name, $signed(bus16.out_sum), e_sum[0]);
    end
    vectors++;
    if (bus16.out_cnt !== 12'(e_cnt[0])) begin
      errors++; $display("FAIL %s cnt16: got %0d required %0d", name, bus16.out_cnt, e_cnt[0]);
    end
    vectors++;
    if (bus16.out_sat !== e_sat[0]) begin
      errors++; $display("FAIL %s sat16: got %0b required %0b", name, bus16.out_sat, e_sat[0]);
    end
    vectors++;
    if (bus8.out_valid !== 1'b1 || bus8.out_sum !== 8'(e_sum[1])) begin
      errors++; $display("FAIL %s sum8: got %0d (valid %0b) required %0d", name, $signed(bus8.out_sum), bus8.out_valid, e_sum[1]);
    end
    vectors++;
    if (bus8.out_cnt !== 6'(e_cnt[1])) begin
      errors++; $display("FAIL %s cnt8: got %0d required %0d", name, bus8.out_cnt, e_cnt[1]);
    end
    vectors++;
    if (bus8.out_sat !== e_sat[1]) begin
      errors++; $display("FAIL %s sat8: got %0b required %0b", name, bus8.out_sat, e_sat[1]);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      vectors++;
      if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'(e_sum[0]) ||
          bus16.out_cnt !== 12'(e_cnt[0]) || bus8.out_sum !== 8'(e_sum[1])) begin
        errors++;
        $display("FAIL %s hold_stable: in_ready=%0b out_valid=%0b sum=%0d cnt=%0d, required 0 1 %0d %0d",
                 name, bus16.in_ready, bus16.out_valid, $signed(bus16.out_sum), bus16.out_cnt, e_sum[0], e_cnt[0]);
      end
    end
    bus16.out_ready = 1'b1;
    while (!en) tick();
    tick();
    bus16.out_ready = 1'b0;
    vectors++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%0b in_ready=%0b, required 0 1", name, bus16.out_valid, bus16.in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.out_sum !== 16'sd0 ||
        bus16.out_cnt !== 12'd0 || bus16.out_sat !== 1'b0 || bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b sum=%0d cnt=%0d sat=%0b, required 1 0 0 0 0",
               name, bus16.in_ready, bus16.out_valid, $signed(bus16.out_sum), bus16.out_cnt, bus16.out_sat);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset_state");
    arst_n = 1'b1;
    model_reset();
    tick();
    check_reset_outputs("after_reset");
  endtask

  task automatic test_single_beat();
    int c[7]; int d[7];
    cate_target = 5'd3;
    for (int i = 0; i < 7; i++) begin c[i] = 3; d[i] = 15; end
    send_beat(7'h7f, c, d, 1'b1, 1'b1);
    vectors++;
    if (bus16.out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: out_valid=%0b one edge after accept, required 0", bus16.out_valid);
    end
    tick();
    vectors++;
    if (bus16.out_valid !== 1'b1 || bus16.out_sum !== 16'sd105) begin
      errors++; $display("FAIL latency: out_valid=%0b sum=%0d two edges after accept, required 1 105",
                         bus16.out_valid, $signed(bus16.out_sum));
    end
    check_result("single_beat", 0);
  endtask

  task automatic test_lanes_036();
    int c[7]; int d[7];
    int dv[3] = '{-16, 5, 1};
    cate_target = 5'd9;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 7; i++) begin
        c[i] = (i % 3 == 0) ? 9 : 10 + i;
        d[i] = (i % 3 == 0) ? dv[b] : int'($urandom_range(0, 31)) - 16;
      end
      send_beat(7'h7f, c, d, b == 0, b == 2);
    end
    check_result("lanes_036", 0);
  endtask

  task automatic test_lane_mask();
    int c[7]; int d[7];
    cate_target = 5'd17;
    for (int i = 0; i < 7; i++) begin c[i] = 17; d[i] = 4; end
    for (int b = 0; b < 4; b++) send_beat(7'b0000001, c, d, b == 0, b == 3);
    check_result("lane_mask", 0);
  endtask

  task automatic test_saturation();
    int c[7]; int d[7];
    cate_target = 5'd0;
    for (int i = 0; i < 7; i++) begin c[i] = 0; d[i] = 15; end
    for (int b = 0; b < 10; b++) send_beat(7'h7f, c, d, b == 0, b == 9);
    check_result("sat_block", 0);
    for (int i = 0; i < 7; i++) d[i] = 1;
    send_beat(7'b0000001, c, d, 1'b1, 1'b1);
    check_result("after_sat", 0);
  endtask

  task automatic test_hold();
    int c[7]; int d[7];
    cate_target = 5'd2;
    for (int i = 0; i < 7; i++) begin c[i] = (i < 4) ? 2 : 1; d[i] = -7 + i; end
    send_beat(7'h7f, c, d, 1'b1, 1'b0);
    send_beat(7'h3c, c, d, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) d[i] = 6 - i;
    present(7'h55, c, d, 1'b1, 1'b0);
    check_result("hold", 5);
    send_beat(7'h55, c, d, 1'b1, 1'b0);
    send_beat(7'h0f, c, d, 1'b0, 1'b1);
    check_result("after_hold", 0);
  endtask

  task automatic test_reset_mid_block();
    int c[7]; int d[7];
    cate_target = 5'd5;
    for (int i = 0; i < 7; i++) begin c[i] = 5; d[i] = 9; end
    send_beat(7'h7f, c, d, 1'b1, 1'b0);
    send_beat(7'h7f, c, d, 1'b0, 1'b0);
    arst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("mid_block_reset");
    arst_n = 1'b1;
    model_reset();
    tick();
    en_rand = 1'b1;
    for (int i = 0; i < 7; i++) d[i] = -3;
    send_beat(7'b0010010, c, d, 1'b1, 1'b1);
    check_result("post_reset_block", 2);
    en_rand = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int c[7]; int d[7];
    logic [6:0] m;
    int nb;
    bit f;
    en_rand = 1'b1;
    for (int blk = 0; blk < 40; blk++) begin
      cate_target = 5'($urandom_range(0, 3));
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
        m = 7'($urandom);
        for (int i = 0; i < 7; i++) begin
          c[i] = int'($urandom_range(0, 3));
          d[i] = int'($urandom_range(0, 31)) - 16;
        end
        f = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
        send_beat(m, c, d, f, b == nb - 1);
      end
      check_result("random", int'($urandom_range(0, 3)));
    end
    en_rand = 1'b0;
    tick();
  endtask

  initial begin
    bus16.in_valid  = 1'b0;
    bus16.in_first  = 1'b0;
    bus16.in_last   = 1'b0;
    bus16.lane_mask = '0;
    bus16.cate      = '0;
    bus16.diff      = '0;
    bus16.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_beat();
    test_lanes_036();
    test_lane_mask();
    test_saturation();
    test_hold();
    test_reset_mid_block();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
